// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one synchronous FIFO write port among N
// valid/ready/last requesters. A grant is held for a whole packet. With
// FIFOARB_BURSTLIMIT_EN defined, a grant is also released after MAXBURST
// accepted beats. Every release costs one IDLE cycle, and then priority
// rotates.
//
// Optional feature macro: FIFOARB_BURSTLIMIT_EN (burst-length limit).
//
// Parameters:
//   N         number of requesters (2..16)
//   DW        data width (matches the FIFO)
//   MAXBURST  beats per grant before forced release (burst limit only, >= 1)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [N]     requester i has a beat
//   req_data   [N*DW]  requester i data on [i*DW +: DW]
//   req_last   [N]     beat is the last beat of the packet
//   req_ready  [N]     beat of requester i accepted (with req_valid[i])
//   grant      [N]     registered one-hot grant, zero when idle
//   wr_en              FIFO write strobe
//   wr_data    [DW]    FIFO write data
//   full               FIFO full flag (only backpressure source)
module fifo_wr_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 16,
  parameter int MAXBURST = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    grant,
  output logic            wr_en,
  output logic [DW-1:0]   wr_data,
  input  logic            full
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  w_grant_nxt;
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_rr_ptr_nxt;

  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_win_idx;
  logic          w_win_found;
  logic          w_hit;
  int            w_idx;
  logic          w_busy;
  logic          w_accept;
  logic          w_release;
  logic          w_burst_hit;

  // Index of the granted requester. The grant is one-hot, so OR-ing the
  // indices of the set bits gives that index without a priority chain.
  always_comb begin
    w_gidx = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_gidx = w_gidx | (r_grant[i] ? PW'(i) : {PW{1'b0}});
    end
  end

  // Round-robin search that starts one past the last winner and wraps.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = {PW{1'b0}};
    w_hit       = 1'b0;
    w_idx       = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx       = (int'(r_rr_ptr) + k) % N;
      w_hit       = !w_win_found && req_valid[w_idx];
      w_win_idx   = w_hit ? PW'(w_idx) : w_win_idx;
      w_win_found = w_win_found | w_hit;
    end
  end

  // Write-port datapath. This path is combinational from the registered
  // grant, req_valid and full. There is no path from req_valid to grant.
  always_comb begin
    w_busy    = (r_state == BUSY);
    w_accept  = w_busy && req_valid[w_gidx] && !full;
    req_ready = (w_busy && !full) ? r_grant : {N{1'b0}};
    wr_en     = w_accept;
    wr_data   = w_busy ? req_data[int'(w_gidx)*DW +: DW] : {DW{1'b0}};
    grant     = r_grant;
  end

`ifdef FIFOARB_BURSTLIMIT_EN
  localparam int CW = $clog2(MAXBURST + 1);

  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] w_beat_cnt_nxt;

  // Beat counter. It is cleared while idle, so each grant starts at zero,
  // and it holds while full or during a bubble.
  always_comb begin
    w_burst_hit = w_accept && (r_beat_cnt == CW'(MAXBURST - 1));
    if (r_state == IDLE) begin
      w_beat_cnt_nxt = {CW{1'b0}};
    end else if (w_accept) begin
      w_beat_cnt_nxt = r_beat_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      w_beat_cnt_nxt = r_beat_cnt;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= {CW{1'b0}};
    end else begin
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end
`else
  assign w_burst_hit = 1'b0;
`endif

  assign w_release = w_accept && (req_last[w_gidx] || w_burst_hit);

  // FSM next state: grant a winner from IDLE, release after the closing beat.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_win_found) begin
          w_state_nxt  = BUSY;
          w_grant_nxt  = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
          w_rr_ptr_nxt = w_win_idx;
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = {N{1'b0}};
        end
      end
      BUSY: begin
        if (w_release) begin
          w_state_nxt = IDLE;
          w_grant_nxt = {N{1'b0}};
        end else begin
          w_state_nxt = BUSY;
          w_grant_nxt = r_grant;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = {N{1'b0}};
      end
    endcase
  end

  // FSM state, grant and round-robin pointer registers. The pointer resets to
  // N-1 so that requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= {N{1'b0}};
      r_rr_ptr <= PW'(N - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port (wr_en / wr_data / full) among N requesters. Each requester presents a valid/ready/last stream. A grant is held for a whole packet, or optionally up to a burst limit, and the arbiter then rotates priority. It sits directly in front of the team's synchronous FIFO and drives its write port; the FIFO's full flag is its only backpressure input.

## Interface
- N, 4: number of requesters (2..16)
- DW, 16: data width, equal to the FIFO DW
- MAXBURST, 8: beats per grant before forced release (used only with FIFOARB_BURSTLIMIT_EN); must be ≥1
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's job
- req_valid  input  N  requester i has a beat on req_data slice i
- req_data  input  N*DW  requester i data on bits [i*DW +: DW]
- req_last  input  N  beat is the final beat of requester i's packet
- req_ready  output  N  beat of requester i accepted this cycle when high together with req_valid[i]
- grant  output  N  one-hot registered grant; all zero when idle
- wr_en  output  1  FIFO write strobe
- wr_data  output  DW  FIFO write data
- full  input  1  FIFO full flag

## Operation
- States: IDLE, BUSY. Registers: state, grant[N], rr_ptr (index of last granted requester), beat_cnt (clog2(MAXBURST+1) bits).
- IDLE: if any req_valid is high, pick the first valid requester searching (rr_ptr+1) mod N upward with wrap. Load grant one-hot, set rr_ptr to the winner, clear beat_cnt, go to BUSY. No beat is transferred in IDLE.
- BUSY, with g as the granted index:
  - req_ready[g] = !full; all other req_ready are 0.
  - wr_en = req_valid[g] && !full; wr_data = req_data slice g.
  - When full is high: no transfer, grant held, beat_cnt held.
  - Accepted beat (wr_en=1): beat_cnt increments.
  - Release condition: accepted beat with req_last[g]=1, or (macro enabled) an accepted beat that makes beat_cnt reach MAXBURST.
  - On release: grant clears and the next state is IDLE.
- In BUSY, req_valid[g] low is a bubble. The grant is held indefinitely; there is no timeout.
- In IDLE, or with no grant, wr_en=0, req_ready=0 and wr_data=0.
- A forced release splits the packet. The requester re-arbitrates for the remainder and its next beat is not last. Packet integrity is the consumer's concern.

## Timing
- Reset values (async, while rst_n=0): state=IDLE, grant=0, rr_ptr=N-1 (so requester 0 has first priority), beat_cnt=0, wr_en=0, req_ready=0, wr_data=0.
- Arbitration latency: 1 cycle. Requests are sampled in IDLE and the grant is visible the next cycle.
- Throughput: 1 beat/cycle while granted and not full.
- Each release costs exactly one IDLE bubble cycle before the next grant.
- wr_en, req_ready and wr_data are combinational from registered grant, req_valid and full. There is no comb path from req_valid to grant.
- Simultaneous requests in IDLE: round-robin order decides.
- A newly asserted request from the just-released requester loses to any other valid requester.
- Reset asserted mid-burst: outputs drop asynchronously and the in-flight beat is not written. After reset, requester 0 has priority.

## Configuration
- FIFOARB_BURSTLIMIT_EN defined: beat_cnt is implemented and a grant is force-released after MAXBURST accepted beats.
- FIFOARB_BURSTLIMIT_EN undefined: no beat_cnt logic. Release happens only on an accepted last beat, and MAXBURST is ignored.

## Test plan
- Reset then single requester: req 2 sends 3 beats (0xA1, 0xA2, 0xA3, last on the 3rd). Expect grant=0100 one cycle after valid, wr_en on 3 consecutive cycles with that data, then grant=0 and IDLE.
- All 4 valid continuously with 1-beat packets after reset. Expect grant order 0,1,2,3,0, with one idle cycle between grants.
- Backpressure: hold full=1 for 5 cycles mid-packet. Expect wr_en=0 and req_ready=0 while full, grant held, and no beat lost or duplicated after full drops.
- Burst limit (macro on, MAXBURST=8): req 1 sends a 12-beat packet while req 3 is waiting. Expect release after beat 8, req 3 granted next, then req 1 granted for the remaining 4 beats. With the macro off, all 12 beats go in one grant.
- Async reset asserted in the middle of the 2nd beat of a 4-beat packet. Expect wr_en, req_ready and grant to go to 0 immediately without waiting for clk. After release, requester 0 wins a simultaneous 0/1 request.
- Bubble: req_valid of the granted requester low for 3 cycles. Expect no wr_en, grant retained, and other requesters' req_ready=0.
